// File: rtl/note_buf_pkg.sv
// Shared types and default constants for the note ping-pong buffer.
package note_buf_pkg;

  localparam int NOTE_LANES = 8;
  localparam int NOTE_DEPTH = 16;
  localparam int NOTE_Y_W   = 8;

  localparam logic [NOTE_Y_W-1:0] NO_NOTE = '1;

  typedef enum logic [1:0] {
    FILL,
    PENDING,
    CLEAR
  } state_e;

endpackage

// File: rtl/note_bank_ram.sv
// One bank of note Y storage: a single write port and a registered read port.
module note_bank_ram #(
  parameter int WORDS = 128,
  parameter int AW    = 7,
  parameter int Y_W   = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [Y_W-1:0] wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [Y_W-1:0] rdata
);

  logic [Y_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The array itself is never reset; only the read register is, and it holds between reads.
  always_ff @(posedge clk) begin
    if (!resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/note_pingpong_buffer.sv
// Tear-free double-buffered note position store: game logic fills the back
// bank, scan-out reads the front bank, banks swap on vsync once a frame is done.
module note_pingpong_buffer
  import note_buf_pkg::*;
#(
  parameter int             LANES         = NOTE_LANES,
  parameter int             DEPTH         = NOTE_DEPTH,
  parameter int             Y_W           = NOTE_Y_W,
  parameter int             CLEAR_ON_SWAP = 1,
  parameter logic [Y_W-1:0] CLEAR_Y       = '1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(LANES)-1:0] wr_lane,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [Y_W-1:0]           wr_y,
  input  logic                     frame_done,
  input  logic                     vsync,
  input  logic                     rd_en,
  input  logic [$clog2(LANES)-1:0] rd_lane,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [Y_W-1:0]           rd_y,
  output logic                     rd_valid,
  output logic                     front_sel,
  output logic                     front_valid,
  output logic [7:0]               repeat_cnt
);

  localparam int WORDS = LANES * DEPTH;
  localparam int AW    = $clog2(LANES) + $clog2(DEPTH);
  localparam state_e RESET_STATE = (CLEAR_ON_SWAP != 0) ? CLEAR : FILL;
  localparam state_e SWAP_STATE  = (CLEAR_ON_SWAP != 0) ? CLEAR : FILL;

  state_e        state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic          front_valid_q, front_valid_d;
  logic [7:0]    repeat_cnt_q, repeat_cnt_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rd_valid_q;
  logic          rd_bank_q;

  logic           swap, bump;
  logic           back_we;
  logic [AW-1:0]  back_addr;
  logic [Y_W-1:0] back_data;
  logic [Y_W-1:0] rdata0, rdata1;

  assign wr_ready  = (state_q == FILL);
  assign back_we   = (wr_valid && wr_ready) || (state_q == CLEAR);
  assign back_addr = (state_q == CLEAR) ? clr_cnt_q : {wr_lane, wr_idx};
  assign back_data = (state_q == CLEAR) ? CLEAR_Y : wr_y;

  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    repeat_cnt_d  = repeat_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    swap          = 1'b0;
    bump          = 1'b0;
    case (state_q)
      FILL: begin
        if (frame_done && vsync) swap = 1'b1;
        else if (frame_done)     state_d = PENDING;
        else if (vsync)          bump = 1'b1;
      end
      PENDING: begin
        if (vsync) swap = 1'b1;
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(WORDS - 1)) begin
          state_d   = FILL;
          clr_cnt_d = '0;
        end
        bump = vsync;
      end
      default: state_d = RESET_STATE;
    endcase
    if (bump && repeat_cnt_q != 8'hFF) repeat_cnt_d = repeat_cnt_q + 8'd1;
    // A swap overrides everything else: the old front becomes the new back.
    if (swap) begin
      front_sel_d   = ~front_sel_q;
      front_valid_d = 1'b1;
      repeat_cnt_d  = 8'd0;
      clr_cnt_d     = '0;
      state_d       = SWAP_STATE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= RESET_STATE;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      repeat_cnt_q  <= 8'd0;
      clr_cnt_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      repeat_cnt_q  <= repeat_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
      rd_valid_q    <= rd_en;
      if (rd_en) rd_bank_q <= front_sel_q;
    end
  end

  note_bank_ram #(.WORDS(WORDS), .AW(AW), .Y_W(Y_W)) u_bank0 (
    .clk   (clk),
    .resetn(resetn),
    .we    (back_we && front_sel_q),
    .waddr (back_addr),
    .wdata (back_data),
    .re    (rd_en && !front_sel_q),
    .raddr ({rd_lane, rd_idx}),
    .rdata (rdata0)
  );

  note_bank_ram #(.WORDS(WORDS), .AW(AW), .Y_W(Y_W)) u_bank1 (
    .clk   (clk),
    .resetn(resetn),
    .we    (back_we && !front_sel_q),
    .waddr (back_addr),
    .wdata (back_data),
    .re    (rd_en && front_sel_q),
    .raddr ({rd_lane, rd_idx}),
    .rdata (rdata1)
  );

  assign rd_y        = rd_bank_q ? rdata1 : rdata0;
  assign rd_valid    = rd_valid_q;
  assign front_sel   = front_sel_q;
  assign front_valid = front_valid_q;
  assign repeat_cnt  = repeat_cnt_q;

endmodule
